// File: rtl/oflow_apb_cfg_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : oflow_apb_cfg_arb                                                |
// | Brief    : Two-requester round-robin APB master with ready-timeout.         |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module oflow_apb_cfg_arb #(
   parameter int ADDR_LEN    = 10,
   parameter int DATA_LEN    = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                reset_N,
   // requester 0
   input  logic                r0_valid,
   input  logic                r0_write,
   input  logic [ADDR_LEN-1:0] r0_addr,
   input  logic [DATA_LEN-1:0] r0_wdata,
   output logic                r0_ready,
   output logic                r0_done,
   output logic [DATA_LEN-1:0] r0_rdata,
   output logic                r0_err,
   // requester 1
   input  logic                r1_valid,
   input  logic                r1_write,
   input  logic [ADDR_LEN-1:0] r1_addr,
   input  logic [DATA_LEN-1:0] r1_wdata,
   output logic                r1_ready,
   output logic                r1_done,
   output logic [DATA_LEN-1:0] r1_rdata,
   output logic                r1_err,
   // APB master
   output logic                apb_psel,
   output logic                apb_penable,
   output logic                apb_pwrite,
   output logic [ADDR_LEN-1:0] apb_addr,
   output logic [DATA_LEN-1:0] apb_pwdata,
   input  logic                apb_pready,
   input  logic [DATA_LEN-1:0] apb_prdata,
   output logic                busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t              state_q,   state_d;
   logic                pref_r1_q, pref_r1_d;
   logic                owner_q,   owner_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                pwrite_q,  pwrite_d;
   logic [ADDR_LEN-1:0] addr_q,    addr_d;
   logic [DATA_LEN-1:0] pwdata_q,  pwdata_d;
   logic                done0_q,   done0_d;
   logic                done1_q,   done1_d;
   logic [DATA_LEN-1:0] rdata0_q,  rdata0_d;
   logic [DATA_LEN-1:0] rdata1_q,  rdata1_d;
   logic                err0_q,    err0_d;
   logic                err1_q,    err1_d;

   logic                grant0;
   logic                grant1;
   logic                idle;
   logic                xfer_end;
   logic                xfer_err;
   logic [DATA_LEN-1:0] xfer_rdata;

   // On a tie the requester not served last wins; grants are mutually exclusive.
   always_comb begin
      grant0 = r0_valid & (~r1_valid | ~pref_r1_q);
      grant1 = r1_valid & (~r0_valid |  pref_r1_q);
   end

   assign idle     = (state_q == ST_IDLE);
   assign r0_ready = idle & grant0;
   assign r1_ready = idle & grant1;

   always_comb begin
      state_d    = state_q;
      pref_r1_d  = pref_r1_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      pwrite_d   = pwrite_q;
      addr_d     = addr_q;
      pwdata_d   = pwdata_q;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      err0_d     = err0_q;
      err1_d     = err1_q;
      xfer_end   = 1'b0;
      xfer_err   = 1'b0;
      xfer_rdata = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant0 | grant1) begin
               state_d   = ST_SETUP;
               owner_d   = grant1;
               pref_r1_d = grant0;
               pwrite_d  = grant1 ? r1_write : r0_write;
               addr_d    = grant1 ? r1_addr  : r0_addr;
               pwdata_d  = grant1 ? r1_wdata : r0_wdata;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + C_CNT_ONE;
            // A ready on the final allowed cycle still counts as a success.
            if (apb_pready) begin
               xfer_end   = 1'b1;
               xfer_rdata = pwrite_q ? '0 : apb_prdata;
            end else if (cnt_q == C_CNT_LAST) begin
               xfer_end = 1'b1;
               xfer_err = 1'b1;
            end
            if (xfer_end) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (xfer_end) begin
         if (owner_q) begin
            done1_d  = 1'b1;
            rdata1_d = xfer_rdata;
            err1_d   = xfer_err;
         end else begin
            done0_d  = 1'b1;
            rdata0_d = xfer_rdata;
            err0_d   = xfer_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_N) begin
         state_q   <= ST_IDLE;
         pref_r1_q <= 1'b0;
         owner_q   <= 1'b0;
         cnt_q     <= '0;
         pwrite_q  <= 1'b0;
         addr_q    <= '0;
         pwdata_q  <= '0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pref_r1_q <= pref_r1_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         pwrite_q  <= pwrite_d;
         addr_q    <= addr_d;
         pwdata_q  <= pwdata_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
      end
   end

   assign apb_psel    = ~idle;
   assign apb_penable = (state_q == ST_ACCESS);
   assign apb_pwrite  = pwrite_q;
   assign apb_addr    = addr_q;
   assign apb_pwdata  = pwdata_q;
   assign busy        = ~idle;

   assign r0_done  = done0_q;
   assign r0_rdata = rdata0_q;
   assign r0_err   = err0_q;
   assign r1_done  = done1_q;
   assign r1_rdata = rdata1_q;
   assign r1_err   = err1_q;

endmodule
`default_nettype wire

// File: tb/tb_oflow_apb_cfg_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_oflow_apb_cfg_arb                                             |
// | Brief    : Randomized scoreboard bench for oflow_apb_cfg_arb.               |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_oflow_apb_cfg_arb;

   localparam int ADDR_LEN    = 10;
   localparam int DATA_LEN    = 32;
   localparam int TIMEOUT_CYC = 16;
   localparam int N_CYC       = 4000;
   localparam int QUIET       = 100;

   logic                clk = 1'b0;
   logic                reset_N;
   logic                r0_valid, r0_write, r0_ready, r0_done, r0_err;
   logic [ADDR_LEN-1:0] r0_addr;
   logic [DATA_LEN-1:0] r0_wdata, r0_rdata;
   logic                r1_valid, r1_write, r1_ready, r1_done, r1_err;
   logic [ADDR_LEN-1:0] r1_addr;
   logic [DATA_LEN-1:0] r1_wdata, r1_rdata;
   logic                apb_psel, apb_penable, apb_pwrite, apb_pready, busy;
   logic [ADDR_LEN-1:0] apb_addr;
   logic [DATA_LEN-1:0] apb_pwdata, apb_prdata;

   oflow_apb_cfg_arb #(
      .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset_N(reset_N),
      .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ready(r0_ready), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ready(r1_ready), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
      .apb_addr(apb_addr), .apb_pwdata(apb_pwdata), .apb_pready(apb_pready),
      .apb_prdata(apb_prdata), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int                  done_cyc;
      logic [DATA_LEN-1:0] rdata;
      logic                err;
   } resp_t;

   typedef struct {
      logic                write;
      logic [ADDR_LEN-1:0] addr;
      logic [DATA_LEN-1:0] wdata;
      int                  delay;
      logic [DATA_LEN-1:0] prdata;
   } apb_t;

   resp_t sb0[$];
   resp_t sb1[$];
   apb_t  apb_q[$];

   logic [DATA_LEN-1:0] last_rd [2];
   logic                last_er [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard side of one requester: pops on done, flags missing dones, checks hold.
   task automatic mon_req(input int x, input logic done, input logic [DATA_LEN-1:0] rd,
                          input logic er, input int c);
      resp_t e;
      bit    have;
      have = (x == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
      if (have) e = (x == 0) ? sb0[0] : sb1[0];
      if (done) begin
         if (!have) begin
            check($sformatf("r%0d_done_unexpected", x), 64'(done), 64'(1'b0));
         end else begin
            if (x == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            check($sformatf("r%0d_done_cycle", x), 64'(c), 64'(e.done_cyc));
            check($sformatf("r%0d_rdata", x), 64'(rd), 64'(e.rdata));
            check($sformatf("r%0d_err", x), 64'(er), 64'(e.err));
            last_rd[x] = e.rdata;
            last_er[x] = e.err;
         end
      end else begin
         if (have && e.done_cyc <= c) begin
            if (x == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            check($sformatf("r%0d_done_missing", x), 64'(done), 64'(1'b1));
         end
         check($sformatf("r%0d_rdata_hold", x), 64'(rd), 64'(last_rd[x]));
         check($sformatf("r%0d_err_hold", x), 64'(er), 64'(last_er[x]));
      end
   endtask

   // Stimulus plus transaction-level reference model.
   initial begin
      bit                  act [2];
      logic                wr  [2];
      logic [ADDR_LEN-1:0] ad  [2];
      logic [DATA_LEN-1:0] wd  [2];
      int    model_free, acc_c, nacc, dly, x, r;
      bit    pref1, rst, quiet, idle, e0, e1, setup, access;
      resp_t rs;
      apb_t  at;
      model_free = 0; acc_c = -100; nacc = 0; pref1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
      end
      reset_N = 1'b1;
      r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;

      for (int c = 1; c < N_CYC; c++) begin
         @(posedge clk);
         #1;
         rst   = (c <= 3) || ($urandom_range(0, 149) == 0);
         quiet = (c > N_CYC - QUIET);
         for (int i = 0; i < 2; i++) begin
            if (act[i] && $urandom_range(0, 31) == 0) begin
               act[i] = 1'b0;
            end else if (!act[i] && !quiet && $urandom_range(0, 2) == 0) begin
               act[i] = 1'b1;
               wr[i]  = 1'($urandom);
               ad[i]  = ADDR_LEN'($urandom);
               wd[i]  = $urandom;
            end
         end
         reset_N  = rst;
         r0_valid = act[0]; r0_write = wr[0]; r0_addr = ad[0]; r0_wdata = wd[0];
         r1_valid = act[1]; r1_write = wr[1]; r1_addr = ad[1]; r1_wdata = wd[1];

         @(negedge clk);
         setup  = (c == acc_c + 1);
         access = (c >= acc_c + 2) && (c <= acc_c + 1 + nacc);
         check("apb_psel", 64'(apb_psel), 64'(setup | access));
         check("apb_penable", 64'(apb_penable), 64'(access));
         check("busy", 64'(busy), 64'(setup | access));

         if (!rst) begin
            idle = (c >= model_free);
            e0   = idle && act[0] && (!act[1] || !pref1);
            e1   = idle && act[1] && (!act[0] ||  pref1);
            check("r0_ready", 64'(r0_ready), 64'(e0));
            check("r1_ready", 64'(r1_ready), 64'(e1));
            if (e0 || e1) begin
               x = e1 ? 1 : 0;
               r = $urandom_range(0, 9);
               if (r <= 5)      dly = $urandom_range(0, 2);
               else if (r == 6) dly = TIMEOUT_CYC - 1;
               else if (r == 7) dly = TIMEOUT_CYC + 3;
               else             dly = 0;
               nacc       = (dly < TIMEOUT_CYC) ? dly + 1 : TIMEOUT_CYC;
               acc_c      = c;
               model_free = c + 2 + nacc;
               at.write   = wr[x]; at.addr = ad[x]; at.wdata = wd[x];
               at.delay   = dly;   at.prdata = $urandom;
               apb_q.push_back(at);
               rs.done_cyc = c + 2 + nacc;
               rs.err      = (dly >= TIMEOUT_CYC);
               rs.rdata    = (rs.err || wr[x]) ? '0 : at.prdata;
               if (x == 0) sb0.push_back(rs); else sb1.push_back(rs);
               pref1  = (x == 0);
               act[x] = 1'b0;
            end
         end else begin
            // Transfers still in flight are abandoned without a done pulse.
            while (sb0.size() > 0 && sb0[$].done_cyc > c) void'(sb0.pop_back());
            while (sb1.size() > 0 && sb1[$].done_cyc > c) void'(sb1.pop_back());
            acc_c = -100; nacc = 0; model_free = c + 1; pref1 = 1'b0;
         end
      end

      @(negedge clk);
      check("sb0_drained", 64'(sb0.size()), 64'(0));
      check("sb1_drained", 64'(sb1.size()), 64'(0));
      check("apb_q_drained", 64'(apb_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // APB slave model: stalls each transfer by its planned delay.
   initial begin
      apb_t cur;
      int   k;
      k = 0;
      cur.write = 1'b0; cur.addr = '0; cur.wdata = '0; cur.delay = 0; cur.prdata = '0;
      apb_pready = 1'b0;
      apb_prdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (apb_psel && !apb_penable) begin
            if (apb_q.size() == 0) begin
               check("apb_setup_unexpected", 64'(apb_psel), 64'(1'b0));
            end else begin
               cur = apb_q.pop_front();
               check("apb_addr_setup", 64'(apb_addr), 64'(cur.addr));
               check("apb_pwrite_setup", 64'(apb_pwrite), 64'(cur.write));
               check("apb_pwdata_setup", 64'(apb_pwdata), 64'(cur.wdata));
            end
            k = 0;
            apb_pready = 1'($urandom);
            apb_prdata = $urandom;
         end else if (apb_psel && apb_penable) begin
            check("apb_addr_access", 64'(apb_addr), 64'(cur.addr));
            check("apb_pwdata_access", 64'(apb_pwdata), 64'(cur.wdata));
            apb_pready = (k == cur.delay);
            apb_prdata = apb_pready ? cur.prdata : $urandom;
            k++;
         end else begin
            apb_pready = 1'($urandom);
            apb_prdata = $urandom;
         end
      end
   end

   // Response monitor.
   initial begin
      bit rst_prev;
      rst_prev = 1'b1;
      last_rd[0] = '0; last_rd[1] = '0;
      last_er[0] = 1'b0; last_er[1] = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            check("rst_r0_done", 64'(r0_done), 64'(1'b0));
            check("rst_r1_done", 64'(r1_done), 64'(1'b0));
            last_rd[0] = '0; last_rd[1] = '0;
            last_er[0] = 1'b0; last_er[1] = 1'b0;
         end
         mon_req(0, r0_done, r0_rdata, r0_err, cyc);
         mon_req(1, r1_done, r1_rdata, r1_err, cyc);
         check("ready_exclusive", 64'(r0_ready & r1_ready), 64'(1'b0));
         rst_prev = reset_N;
      end
   end

endmodule
`default_nettype wire

// File: doc/oflow_apb_cfg_arb.md
Name: oflow_apb_cfg_arb

Overview:
APB master and arbiter in front of the oflow register file's APB slave port (weights w_iou/w_w/w_h/w_color1/w_color2/w_dhistory, num_of_history_frame, score_th_for_new_bbox). Two requesters share the single slave: r0 is the host/CPU config path and r1 is the frame-level controller, for example per-frame threshold updates. The block grants requesters round-robin, runs the APB SETUP/ACCESS sequence and waits on apb_pready with a timeout. It returns read data or an error to the requester.

Parameters:
ADDR_LEN, 10, APB address width (matches the `ADDR_LEN` define).
DATA_LEN, 32, APB data width.
TIMEOUT_CYC, 16, maximum number of ACCESS cycles without apb_pready before the transfer is aborted (≥2).

Ports:
clk  in  1  system clock, rising edge.
reset_N  in  1  synchronous reset, active-high (1 = reset).
r0_valid  in  1  r0 request pending; held until r0_ready.
r0_write  in  1  1 = write, 0 = read.
r0_addr  in  ADDR_LEN  register address.
r0_wdata  in  DATA_LEN  write data.
r0_ready  out  1  request accepted this cycle.
r0_done  out  1  one-cycle completion pulse.
r0_rdata  out  DATA_LEN  read data, valid with r0_done.
r0_err  out  1  timeout flag, valid with r0_done.
r1_valid / r1_write / r1_addr / r1_wdata / r1_ready / r1_done / r1_rdata / r1_err: same as r0, for requester 1.
apb_psel  out  1  APB select.
apb_penable  out  1  APB enable.
apb_pwrite  out  1  APB direction.
apb_addr  out  ADDR_LEN  APB address.
apb_pwdata  out  DATA_LEN  APB write data.
apb_pready  in  1  slave ready.
apb_prdata  in  DATA_LEN  slave read data.
busy  out  1  high in SETUP/ACCESS.

Behaviour:
- Reset (sampled on a clk edge while reset_N=1):
  - state=IDLE; all outputs 0; round-robin pointer prefers r0; timeout counter 0.
  - Applies mid-transfer too: psel and penable are 0 after that edge, and no done pulse is issued for the aborted transfer.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - psel=0, penable=0.
  - Grant is combinational: rX_ready = (state==IDLE) & grantX.
  - If only one valid, grant it. If both valid, grant the one not served last. After reset, r0 wins the first tie.
  - On the ready edge, latch write/addr/wdata into the apb_* registers, record the owner, update the pointer, go to SETUP.
- SETUP (1 cycle): psel=1, penable=0; go to ACCESS.
- ACCESS:
  - psel=1, penable=1; the counter increments each ACCESS cycle.
  - If apb_pready=1: capture apb_prdata (reads only; writes return 0), go to IDLE, and pulse owner done with err=0 in the following cycle.
  - Else if the counter reaches TIMEOUT_CYC: go to IDLE, pulse done with err=1 and rdata=0.
  - The counter clears on leaving ACCESS.
- rdata/err are registered; they hold their value after done until the next done for that requester.
- apb_addr/apb_pwdata/apb_pwrite hold their last values in IDLE.
- Latency, with pready high on the first ACCESS cycle:
  - grant at T0, SETUP at T1, ACCESS at T2, done at T3.
  - A new grant is allowed in the same cycle as done (T3), so throughput is one transfer per 3 cycles.
- Request fields are sampled only on the ready cycle. Dropping valid before ready withdraws the request with no effect.
- A requester may not be granted twice in a row while the other is valid.
- apb_prdata is ignored outside an ACCESS cycle with pready=1.
- busy = (state != IDLE).

Test Plan:
1. r0 write addr 0x004 data 0x5, apb_pready tied 1 -> apb_psel=1/penable=0 at T1, penable=1 at T2, r0_done=1 with r0_err=0 at T3; apb_pwdata=0x5 throughout SETUP/ACCESS.
2. r1 read addr 0x000, pready low for 2 ACCESS cycles then high with prdata=0x00000180 -> 3 ACCESS cycles, r1_done with r1_rdata=0x180, r1_err=0; r0 outputs stay unchanged.
3. r0_valid and r1_valid both held high after reset, pready=1 -> grant order r0, r1, r0, r1; each transfer takes 3 cycles; readies are never asserted together.
4. r0 read with pready stuck low, TIMEOUT_CYC=16 -> exactly 16 ACCESS cycles, psel drops, r0_done=1, r0_err=1, r0_rdata=0, busy=0.
5. reset_N pulsed high during the second ACCESS cycle of an r1 read -> next cycle psel=penable=0, busy=0, no r1_done; a following tie grants r0.
6. r0 asserts a new valid in its own done cycle while r1 is idle -> r0_ready in that same cycle; two writes complete 3 cycles apart.
